// File: rtl/ls_queue_unit.sv
// Load/store queue pair: two independent DEPTH-entry FIFOs sharing enable, flush and reset.
// Define LS_QUEUE_CUTTHROUGH_EN to add a zero-latency bypass when a queue is empty.

module ls_queue_fifo #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       i_resetn,
    input  logic                       i_enable,
    input  logic                       i_flush,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [DATA_WIDTH-1:0]      i_in_data,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [DATA_WIDTH-1:0]      o_out_data,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;

    logic w_live;
    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_skip;
    logic w_wr;
    logic w_rd;

    assign w_live     = i_enable && !i_flush;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign o_in_ready = w_live && !w_full;

`ifdef LS_QUEUE_CUTTHROUGH_EN
    logic w_thru;

    // Empty queue forwards the producer straight to the consumer; held in reset it shows nothing.
    assign w_thru      = w_live && i_resetn && w_empty;
    assign o_out_valid = w_thru ? i_in_valid : (w_live && !w_empty);
    assign o_out_data  = w_thru ? i_in_data  : r_mem[r_rptr];
    assign w_skip      = w_thru && i_in_valid && i_out_ready;
`else
    assign o_out_valid = w_live && !w_empty;
    assign o_out_data  = r_mem[r_rptr];
    assign w_skip      = 1'b0;
`endif

    assign w_push = i_in_valid && o_in_ready;
    assign w_pop  = o_out_valid && i_out_ready;
    // A bypassed item is never written; a pop only touches storage when it holds something.
    assign w_wr   = w_push && !w_skip;
    assign w_rd   = w_pop && !w_empty;

    always_ff @(posedge clk) begin
        if (!i_resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= i_in_data;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + CW'(1);
            end else if (!w_wr && w_rd) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign o_count = r_count;

endmodule

module ls_queue_unit #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       enable,
    input  logic                       flush,
    input  logic                       ld_in_valid,
    output logic                       ld_in_ready,
    input  logic [DATA_WIDTH-1:0]      ld_in_data,
    output logic                       ld_out_valid,
    input  logic                       ld_out_ready,
    output logic [DATA_WIDTH-1:0]      ld_out_data,
    input  logic                       st_in_valid,
    output logic                       st_in_ready,
    input  logic [DATA_WIDTH-1:0]      st_in_data,
    output logic                       st_out_valid,
    input  logic                       st_out_ready,
    output logic [DATA_WIDTH-1:0]      st_out_data,
    output logic [$clog2(DEPTH):0]     ld_count,
    output logic [$clog2(DEPTH):0]     st_count
);

    ls_queue_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ld_q (
        .clk         (clk),
        .i_resetn    (resetn),
        .i_enable    (enable),
        .i_flush     (flush),
        .i_in_valid  (ld_in_valid),
        .o_in_ready  (ld_in_ready),
        .i_in_data   (ld_in_data),
        .o_out_valid (ld_out_valid),
        .i_out_ready (ld_out_ready),
        .o_out_data  (ld_out_data),
        .o_count     (ld_count)
    );

    ls_queue_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_st_q (
        .clk         (clk),
        .i_resetn    (resetn),
        .i_enable    (enable),
        .i_flush     (flush),
        .i_in_valid  (st_in_valid),
        .o_in_ready  (st_in_ready),
        .i_in_data   (st_in_data),
        .o_out_valid (st_out_valid),
        .i_out_ready (st_out_ready),
        .o_out_data  (st_out_data),
        .o_count     (st_count)
    );

endmodule

// File: doc/ls_queue_unit.md
LS_QUEUE_UNIT -- requirements
Module: ls_queue_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width in bits of every data path.
REQ-002 Parameter DEPTH, default 4, entries per queue; power of two, >= 2.
REQ-003 Derived CW = log2(DEPTH)+1, width of the occupancy outputs.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 enable  in  1  global enable; low freezes both queues.
REQ-007 flush  in  1  synchronous clear of both queues.
REQ-008 ld_in_valid / ld_in_ready  in / out  1 / 1  load-side producer handshake.
REQ-009 ld_in_data  in  DATA_WIDTH  load data from memory side.
REQ-010 ld_out_valid / ld_out_ready  out / in  1 / 1  load-side consumer handshake.
REQ-011 ld_out_data  out  DATA_WIDTH  load data to datapath.
REQ-012 st_in_valid / st_in_ready  in / out  1 / 1  store-side producer handshake.
REQ-013 st_in_data  in  DATA_WIDTH  store data from datapath.
REQ-014 st_out_valid / st_out_ready  out / in  1 / 1  store-side consumer handshake.
REQ-015 st_out_data  out  DATA_WIDTH  store data to memory side.
REQ-016 ld_count / st_count  out  CW  current occupancy of each queue.

Function
REQ-017 Load and store queues SHALL be independent, identical FIFOs; rules below apply to each.
REQ-018 Push occurs on a cycle where in_valid && in_ready; pop where out_valid && out_ready.
REQ-019 in_ready SHALL equal enable && !flush && (count < DEPTH); no push-on-pop when full.
REQ-020 out_valid SHALL equal enable && !flush && (count > 0); out_data SHALL be the oldest entry, stable until popped.
REQ-021 Latency: data pushed at edge N SHALL appear on out_data, out_valid high, in the cycle after edge N.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-024 enable low: no push, no pop, pointers, count and contents held; out_data holds last value.
REQ-025 flush high: at the next edge both counts and pointers SHALL be 0; transfers offered in the flush cycle discarded.
REQ-026 flush and resetn both active: reset behaviour applies.
REQ-027 ld_count/st_count SHALL be registered and reflect occupancy after the most recent edge.

Reset
REQ-028 With resetn low at an edge: pointers, counts and all storage entries SHALL become 0.
REQ-029 During and after reset, until first push: out_valid 0, out_data 0, count 0; in_ready follows REQ-019.
REQ-030 Reset asserted mid-transfer SHALL discard all queued data; no partial entry survives.

Configuration
REQ-031 Macro LS_QUEUE_CUTTHROUGH_EN SHALL control zero-latency bypass on both queues.
REQ-032 Defined: when count == 0, enable high, flush low, out_valid SHALL equal in_valid and out_data SHALL equal in_data combinationally; if out_ready also high the item is consumed without being stored, count stays 0.
REQ-033 Defined, count == 0, in_valid high, out_ready low: item SHALL be stored normally (count becomes 1).
REQ-034 Not defined: no combinational in-to-out path; minimum latency one cycle per REQ-021.

Verification
REQ-035 Reset: resetn low 2 cycles with in_valid=1 -> out_valid=0, out_data=0, count=0, no push recorded.
REQ-036 Fill/drain, DEPTH=4: push 0xA0..0xA4 with out_ready=0 -> 4 accepted, in_ready=0 at count=4; drain -> A0,A1,A2,A3 in order, count 4->0.
REQ-037 Streaming: in_valid=out_ready=1 for 10 cycles, data 1..10 -> count steady at 1 (0 with cut-through), output sequence 1..10, pointers wrap without loss.
REQ-038 Enable: 2 entries queued, enable=0 for 3 cycles with out_ready=1 -> out_valid=0, count stays 2; enable=1 -> both pop in order.
REQ-039 Flush: 3 entries queued, flush=1 with simultaneous push -> next cycle count=0, out_valid=0, pushed item absent.
REQ-040 Cut-through (macro defined): empty queue, in_valid=1, in_data=0x55, out_ready=1 -> out_valid=1, out_data=0x55 same cycle, count remains 0.
